// File: rtl/commit_trace_monitor.sv
// Retire-stage commit monitor: classifies accepted commits, tags them with an
// instruction number, buffers them in a first-word-fall-through FIFO with a
// valid/ready drain port, and tracks cycle/instruction/drop counters plus
// halt, watchdog and overflow status.
module commit_trace_monitor #(
  parameter int DATA_W      = 16,
  parameter int REG_W       = 4,
  parameter int DEPTH       = 8,
  parameter int CNT_W       = 32,
  parameter int CYCLE_LIMIT = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cm_valid,
  input  logic [DATA_W-1:0] cm_pc,
  input  logic              cm_regwrite,
  input  logic [REG_W-1:0]  cm_wreg,
  input  logic [DATA_W-1:0] cm_wdata,
  input  logic              cm_memread,
  input  logic              cm_memwrite,
  input  logic [DATA_W-1:0] cm_maddr,
  input  logic [DATA_W-1:0] cm_mdata,
  input  logic              cm_halt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_kind,
  output logic [CNT_W-1:0]  out_inum,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_value,
  output logic [DATA_W-1:0] out_addr,
  output logic [REG_W-1:0]  out_reg,
  output logic [CNT_W-1:0]  inst_count,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  drop_count,
  output logic              halted,
  output logic              timeout,
  output logic              overflow,
  output logic              done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic [2:0] {
    KIND_ALU   = 3'd0,
    KIND_LOAD  = 3'd1,
    KIND_STORE = 3'd2,
    KIND_OTHER = 3'd3,
    KIND_HALT  = 3'd4
  } kind_e;

  typedef struct packed {
    kind_e             kind;
    logic [CNT_W-1:0]  inum;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] value;
    logic [DATA_W-1:0] addr;
    logic [REG_W-1:0]  rg;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic [CNT_W-1:0]   inst_count_q, inst_count_d;
  logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0]   drop_count_q, drop_count_d;
  logic               halted_q, halted_d;
  logic               timeout_q, timeout_d;
  logic               overflow_q, overflow_d;

  logic               running, accept, empty, full, pop, push, drop;
  entry_t             new_entry;
  entry_t             head;

  // Handshake qualifiers derived from registered state.
  always_comb begin
    running = ~halted_q & ~timeout_q;
    accept  = cm_valid & running;
    empty   = (occ_q == '0);
    full    = (occ_q == OCC_W'(DEPTH));
    pop     = ~empty & out_ready;
    push    = accept & (~full | pop);
    drop    = accept & full & ~pop;
  end

  // Classify the committing instruction and build its trace entry.
  always_comb begin
    new_entry      = '0;
    new_entry.pc   = cm_pc;
    new_entry.inum = inst_count_q;
    if (cm_halt) begin
      new_entry.kind = KIND_HALT;
    end else if (cm_regwrite & cm_memread) begin
      new_entry.kind  = KIND_LOAD;
      new_entry.value = cm_wdata;
      new_entry.rg    = cm_wreg;
      new_entry.addr  = cm_maddr;
    end else if (cm_regwrite) begin
      new_entry.kind  = KIND_ALU;
      new_entry.value = cm_wdata;
      new_entry.rg    = cm_wreg;
    end else if (cm_memwrite) begin
      new_entry.kind  = KIND_STORE;
      new_entry.value = cm_mdata;
      new_entry.addr  = cm_maddr;
    end else begin
      new_entry.kind = KIND_OTHER;
    end
  end

  // Next-state for FIFO storage, pointers, counters and status flags.
  always_comb begin
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    occ_d         = occ_q;
    inst_count_d  = inst_count_q;
    cycle_count_d = cycle_count_q;
    drop_count_d  = drop_count_q;
    halted_d      = halted_q;
    timeout_d     = timeout_q;
    overflow_d    = overflow_q;

    if (push) begin
      mem_d[wr_ptr_q] = new_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    if (accept) begin
      inst_count_d = inst_count_q + CNT_W'(1);
      if (cm_halt) halted_d = 1'b1;
    end
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != '1) drop_count_d = drop_count_q + CNT_W'(1);
    end

    if (running && cycle_count_q != '1) begin
      cycle_count_d = cycle_count_q + CNT_W'(1);
      if (cycle_count_d == CNT_W'(CYCLE_LIMIT)) timeout_d = 1'b1;
    end
  end

  // Control and status registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      occ_q         <= '0;
      inst_count_q  <= '0;
      cycle_count_q <= '0;
      drop_count_q  <= '0;
      halted_q      <= 1'b0;
      timeout_q     <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      occ_q         <= occ_d;
      inst_count_q  <= inst_count_d;
      cycle_count_q <= cycle_count_d;
      drop_count_q  <= drop_count_d;
      halted_q      <= halted_d;
      timeout_q     <= timeout_d;
      overflow_q    <= overflow_d;
    end
  end

  // Entry storage; contents are don't-care whenever the occupancy says empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Head fields are forced to zero while empty so that storage left
  // uninitialised (or stale after a reset) never shows on the outputs.
  assign head        = mem_q[rd_ptr_q];
  assign out_valid   = ~empty;
  assign out_kind    = out_valid ? head.kind  : 3'd0;
  assign out_inum    = out_valid ? head.inum  : '0;
  assign out_pc      = out_valid ? head.pc    : '0;
  assign out_value   = out_valid ? head.value : '0;
  assign out_addr    = out_valid ? head.addr  : '0;
  assign out_reg     = out_valid ? head.rg    : '0;
  assign inst_count  = inst_count_q;
  assign cycle_count = cycle_count_q;
  assign drop_count  = drop_count_q;
  assign halted      = halted_q;
  assign timeout     = timeout_q;
  assign overflow    = overflow_q;
  assign done        = (halted_q | timeout_q) & empty;

endmodule

// File: tb/tb_commit_trace_monitor.sv
// Bench for commit_trace_monitor: directed scenarios plus randomized episodes,
// all compared every cycle against a queue-based reference model.
module tb_commit_trace_monitor;

  localparam int DW    = 16;
  localparam int RW    = 4;
  localparam int DEPTH = 8;
  localparam int CW    = 32;
  localparam int LIMIT = 20;

  localparam int OP_ALU = 0, OP_LD = 1, OP_ST = 2, OP_BR = 3, OP_HLT = 4, OP_BUB = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cm_valid, cm_regwrite, cm_memread, cm_memwrite, cm_halt;
  logic [DW-1:0] cm_pc, cm_wdata, cm_maddr, cm_mdata;
  logic [RW-1:0] cm_wreg;
  logic          out_valid, out_ready;
  logic [2:0]    out_kind;
  logic [CW-1:0] out_inum, inst_count, cycle_count, drop_count;
  logic [DW-1:0] out_pc, out_value, out_addr;
  logic [RW-1:0] out_reg;
  logic          halted, timeout, overflow, done;

  commit_trace_monitor #(
    .DATA_W(DW), .REG_W(RW), .DEPTH(DEPTH), .CNT_W(CW), .CYCLE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cm_valid(cm_valid), .cm_pc(cm_pc), .cm_regwrite(cm_regwrite),
    .cm_wreg(cm_wreg), .cm_wdata(cm_wdata), .cm_memread(cm_memread),
    .cm_memwrite(cm_memwrite), .cm_maddr(cm_maddr), .cm_mdata(cm_mdata),
    .cm_halt(cm_halt),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_inum(out_inum), .out_pc(out_pc), .out_value(out_value),
    .out_addr(out_addr), .out_reg(out_reg),
    .inst_count(inst_count), .cycle_count(cycle_count), .drop_count(drop_count),
    .halted(halted), .timeout(timeout), .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    kind;
    logic [CW-1:0] inum;
    logic [DW-1:0] pc, value, addr;
    logic [RW-1:0] rg;
  } ent_t;

  ent_t          q[$];
  logic [CW-1:0] m_inst, m_cycle, m_drop;
  bit            m_halt, m_to, m_ovf;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference: one clock edge worth of architectural effect from current inputs.
  task automatic model_step();
    ent_t e;
    bit   acc, pop, was_full, run;
    if (!rst_n) begin
      q.delete();
      m_inst = 0; m_cycle = 0; m_drop = 0;
      m_halt = 0; m_to = 0; m_ovf = 0;
      return;
    end
    run      = !m_halt && !m_to;
    acc      = cm_valid && run;
    was_full = (q.size() == DEPTH);
    pop      = (q.size() > 0) && out_ready;
    if (pop) void'(q.pop_front());
    if (acc) begin
      e = '{kind: 3'd3, inum: m_inst, pc: cm_pc, value: '0, addr: '0, rg: '0};
      if (cm_halt)                      e.kind = 3'd4;
      else if (cm_regwrite && cm_memread) begin
        e.kind = 3'd1; e.value = cm_wdata; e.rg = cm_wreg; e.addr = cm_maddr;
      end else if (cm_regwrite) begin
        e.kind = 3'd0; e.value = cm_wdata; e.rg = cm_wreg;
      end else if (cm_memwrite) begin
        e.kind = 3'd2; e.value = cm_mdata; e.addr = cm_maddr;
      end
      m_inst++;
      if (!was_full || pop) q.push_back(e);
      else begin
        m_ovf = 1;
        if (m_drop != 32'hFFFF_FFFF) m_drop++;
      end
      if (cm_halt) m_halt = 1;
    end
    if (run && m_cycle != 32'hFFFF_FFFF) begin
      m_cycle++;
      if (m_cycle == LIMIT) m_to = 1;
    end
  endtask

  task automatic compare_all();
    check_eq("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      check_eq("out_kind",  out_kind,  q[0].kind);
      check_eq("out_inum",  out_inum,  q[0].inum);
      check_eq("out_pc",    out_pc,    q[0].pc);
      check_eq("out_value", out_value, q[0].value);
      check_eq("out_addr",  out_addr,  q[0].addr);
      check_eq("out_reg",   out_reg,   q[0].rg);
    end
    check_eq("inst_count",  inst_count,  m_inst);
    check_eq("cycle_count", cycle_count, m_cycle);
    check_eq("drop_count",  drop_count,  m_drop);
    check_eq("halted",      halted,      m_halt);
    check_eq("timeout",     timeout,     m_to);
    check_eq("overflow",    overflow,    m_ovf);
    check_eq("done",        done,        (m_halt || m_to) && q.size() == 0);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input int op, input logic [DW-1:0] pc, input logic [RW-1:0] rg,
                       input logic [DW-1:0] data, input logic [DW-1:0] addr);
    cm_valid    = (op != OP_BUB);
    cm_pc       = pc;
    cm_wreg     = rg;
    cm_wdata    = data;
    cm_mdata    = data;
    cm_maddr    = addr;
    cm_regwrite = (op == OP_ALU) || (op == OP_LD);
    cm_memread  = (op == OP_LD);
    cm_memwrite = (op == OP_ST);
    cm_halt     = (op == OP_HLT);
  endtask

  task automatic rand_drive(input int halt_pct);
    cm_valid    = ($urandom_range(3) != 0);
    cm_pc       = DW'($urandom);
    cm_regwrite = $urandom_range(1);
    cm_wreg     = RW'($urandom);
    cm_wdata    = DW'($urandom);
    cm_memread  = $urandom_range(1);
    cm_memwrite = $urandom_range(1);
    cm_maddr    = DW'($urandom);
    cm_mdata    = DW'($urandom);
    cm_halt     = ($urandom_range(99) < halt_pct);
    out_ready   = $urandom_range(1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rand_drive(50);
    cm_valid = 1'b1;
    repeat (2) step();
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_kind", out_kind, 0);
    check_eq("rst_inum", out_inum, 0);
    check_eq("rst_cycle", cycle_count, 0);
    check_eq("rst_inst", inst_count, 0);
    check_eq("rst_done", done, 0);
    rst_n = 1'b1;
  endtask

  logic [15:0] t2_val  [5] = '{16'h0005, 16'h1234, 16'hBEEF, 16'h0000, 16'h0000};
  logic [15:0] t2_addr [5] = '{16'h0000, 16'h0010, 16'h0020, 16'h0000, 16'h0000};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b0;
    drive(OP_BUB, '0, '0, '0, '0);

    // T1: reset then first commit gets inum 0
    do_reset();
    out_ready = 1'b0;
    drive(OP_ALU, 16'h0100, 4'd1, 16'h00AA, 16'h5555);
    step();
    check_eq("t1_valid", out_valid, 1);
    check_eq("t1_inum", out_inum, 0);

    // T2: classification of each kind, bubble ignored
    do_reset();
    out_ready = 1'b0;
    drive(OP_ALU, 16'h0000, 4'd3, 16'h0005, 16'h7777); step();
    drive(OP_LD,  16'h0002, 4'd4, 16'h1234, 16'h0010); step();
    drive(OP_ST,  16'h0004, 4'd9, 16'hBEEF, 16'h0020); step();
    drive(OP_BUB, 16'h0006, 4'd2, 16'h1111, 16'h2222); step();
    drive(OP_BR,  16'h0008, 4'd5, 16'h3333, 16'h4444); step();
    drive(OP_HLT, 16'h000A, 4'd6, 16'h5555, 16'h6666); step();
    drive(OP_ALU, 16'h000C, 4'd7, 16'h9999, 16'h8888);
    check_eq("t2_inst", inst_count, 5);
    check_eq("t2_halted", halted, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_eq("t2_kind", out_kind, 64'(i));
      check_eq("t2_inum", out_inum, 64'(i));
      check_eq("t2_value", out_value, t2_val[i]);
      check_eq("t2_addr", out_addr, t2_addr[i]);
      step();
    end
    check_eq("t2_empty", out_valid, 0);

    // T3: overflow drops two of ten
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(OP_ALU, 16'(i * 4), 4'(i), 16'(i + 16'h100), 16'h0);
      step();
    end
    check_eq("t3_drop", drop_count, 2);
    check_eq("t3_ovf", overflow, 1);
    check_eq("t3_inst", inst_count, 10);
    drive(OP_BUB, '0, '0, '0, '0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_eq("t3_inum", out_inum, 64'(i));
      step();
    end
    check_eq("t3_empty", out_valid, 0);

    // T4: full with simultaneous pop accepts both
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(OP_ST, 16'(i), 4'(i), 16'(i + 16'h40), 16'(i + 16'h80));
      step();
    end
    out_ready = 1'b1;
    drive(OP_ALU, 16'h0F00, 4'd8, 16'h0F0F, 16'h0);
    step();
    check_eq("t4_head", out_inum, 1);
    check_eq("t4_drop", drop_count, 0);
    check_eq("t4_inst", inst_count, 9);
    out_ready = 1'b0;
    drive(OP_BR, 16'h0F02, 4'd0, 16'h0, 16'h0);
    step();
    check_eq("t4_still_full", drop_count, 1);

    // T5: watchdog
    do_reset();
    for (int i = 0; i < 25; i++) begin
      rand_drive(0);
      step();
    end
    check_eq("t5_timeout", timeout, 1);
    check_eq("t5_cycle", cycle_count, LIMIT);
    for (int i = 0; i < 4; i++) begin
      drive(OP_ALU, 16'h1, 4'd1, 16'h1, 16'h1);
      out_ready = 1'b0;
      step();
    end
    check_eq("t5_frozen", cycle_count, LIMIT);

    // T6: drain after halt, done on emptying
    do_reset();
    out_ready = 1'b0;
    drive(OP_ALU, 16'h0010, 4'd1, 16'h0001, 16'h0); step();
    drive(OP_LD,  16'h0012, 4'd2, 16'h0002, 16'h0030); step();
    drive(OP_HLT, 16'h0014, 4'd0, 16'h0, 16'h0); step();
    drive(OP_BUB, '0, '0, '0, '0);
    check_eq("t6_done_pre", done, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_eq("t6_inum", out_inum, 64'(i));
      check_eq("t6_done_mid", done, 0);
      step();
    end
    check_eq("t6_done", done, 1);

    // Randomized episodes, each starting with a reset (also exercises mid-run reset)
    for (int ep = 0; ep < 8; ep++) begin
      do_reset();
      for (int i = 0; i < 40; i++) begin
        rand_drive(4);
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
